// File: rtl/lector_capa_pkg.sv
// ============================================================================
// Module : lector_capa_pkg
// Brief  : Shared constants, FSM encoding and arbitration helpers for lector_capa.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lector_capa_pkg;

    localparam int NUM_PORTS = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    localparam logic [2:0] IDX_TOTAL = 3'd4;

    typedef logic [1:0] port_t;

    // Returns {found, port}: first candidate at or after ptr, wrapping around.
    function automatic logic [2:0] rr_pick(input logic [NUM_PORTS-1:0] cand, input port_t ptr);
        logic [2:0] pick;
        port_t      k;
        pick = 3'b000;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            k = ptr + port_t'(i);
            if (cand[k]) pick = {1'b1, k};
        end
        return pick;
    endfunction

    function automatic port_t onehot_to_port(input logic [NUM_PORTS-1:0] oh);
        port_t p;
        p = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) p = port_t'(i);
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lector_capa_if.sv
// ============================================================================
// Module : lector_capa_if
// Brief  : Output word stream and counter-read port of lector_capa.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lector_capa_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            port_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  req;
    logic [2:0]            idx;
    logic [CNT_WIDTH-1:0]  salida_contador;
    logic                  valid_contador;

    modport master (
        output data_out, port_out, valid_out, salida_contador, valid_contador,
        input  ready_out, req, idx
    );

    modport slave (
        input  data_out, port_out, valid_out, salida_contador, valid_contador,
        output ready_out, req, idx
    );
endinterface

`default_nettype wire

// File: rtl/lector_capa_buffer_salida_2.sv
// ============================================================================
// Module : buffer_salida_2
// Brief  : Two-entry in-order output FIFO holding a data word and its port tag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module buffer_salida_2
    import lector_capa_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  enq,
    input  wire logic [DATA_WIDTH-1:0] enq_data,
    input  wire port_t                 enq_port,
    input  wire logic                  deq,
    output logic [DATA_WIDTH-1:0]      data_out,
    output port_t                      port_out,
    output logic                       valid,
    output logic [1:0]                 occupancy
);

    logic [DATA_WIDTH-1:0] r_data [2];
    port_t                 r_port [2];
    logic                  r_rd;
    logic                  r_wr;
    logic [1:0]            r_count;
    logic                  w_deq;

    assign w_deq = deq && (r_count != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_port[i] <= '0;
            end
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (enq) begin
                r_data[r_wr] <= enq_data;
                r_port[r_wr] <= enq_port;
                r_wr         <= ~r_wr;
            end
            if (w_deq) r_rd <= ~r_rd;
            case ({enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out  = r_data[r_rd];
    assign port_out  = r_port[r_rd];
    assign valid     = (r_count != 2'd0);
    assign occupancy = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(enq && !w_deq && (r_count == 2'd2)));

endmodule

`default_nettype wire

// File: rtl/lector_capa.sv
// ============================================================================
// Module : lector_capa
// Brief  : Round-robin drain reader for four blue FIFOs with per-port counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lector_capa
    import lector_capa_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  Enable,
    input  wire logic [NUM_PORTS-1:0]  fifo_empty,
    input  wire logic [DATA_WIDTH-1:0] data_in_p0,
    input  wire logic [DATA_WIDTH-1:0] data_in_p1,
    input  wire logic [DATA_WIDTH-1:0] data_in_p2,
    input  wire logic [DATA_WIDTH-1:0] data_in_p3,
    output logic [NUM_PORTS-1:0]       pop_fifo_azules,
    output logic                       idle,
    lector_capa_if.master              bus
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    port_t                 r_ptr;
    logic [NUM_PORTS-1:0]  r_pop;
    logic                  r_tag_vld;
    port_t                 r_tag_port;
    logic [CNT_WIDTH-1:0]  r_cnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  r_total;
    logic [CNT_WIDTH-1:0]  r_salida;
    logic                  r_valid_cnt;

    logic [1:0]            w_occ;
    logic                  w_valid;
    logic                  w_deq;
    logic [2:0]            w_load;
    logic                  w_room;
    logic [NUM_PORTS-1:0]  w_cand;
    logic [2:0]            w_pick;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_enq_data;
    logic [DATA_WIDTH-1:0] w_buf_data;
    port_t                 w_buf_port;
    logic [CNT_WIDTH-1:0]  w_sel_cnt;

    assign w_deq = w_valid && bus.ready_out;

    // Credit check covers both pipeline stages: the pop on the wire and the word being captured.
    assign w_load  = {1'b0, w_occ} + {2'b00, |r_pop} + {2'b00, r_tag_vld};
    assign w_room  = (w_load - {2'b00, w_deq}) < 3'd2;
    assign w_cand  = ~fifo_empty & ~r_pop;
    assign w_pick  = rr_pick(w_cand, r_ptr);
    assign w_issue = (r_state == ACTIVE) && Enable && w_room && w_pick[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (Enable) r_state <= ACTIVE;
                ACTIVE:  if (!Enable) r_state <= DRAIN;
                DRAIN: begin
                    if (Enable)
                        r_state <= ACTIVE;
                    else if ((r_pop == '0) && !r_tag_vld && (w_occ == 2'd0))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop      <= '0;
            r_ptr      <= '0;
            r_tag_vld  <= 1'b0;
            r_tag_port <= '0;
        end else begin
            r_pop      <= w_issue ? (4'b0001 << w_pick[1:0]) : 4'b0000;
            if (w_issue) r_ptr <= w_pick[1:0] + 2'd1;
            r_tag_vld  <= |r_pop;
            r_tag_port <= onehot_to_port(r_pop);
        end
    end

    always_comb begin
        w_enq_data = data_in_p0;
        case (r_tag_port)
            2'd1:    w_enq_data = data_in_p1;
            2'd2:    w_enq_data = data_in_p2;
            2'd3:    w_enq_data = data_in_p3;
            default: w_enq_data = data_in_p0;
        endcase
    end

    buffer_salida_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .enq       (r_tag_vld),
        .enq_data  (w_enq_data),
        .enq_port  (r_tag_port),
        .deq       (w_deq),
        .data_out  (w_buf_data),
        .port_out  (w_buf_port),
        .valid     (w_valid),
        .occupancy (w_occ)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
            r_total <= '0;
        end else if (w_deq) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_buf_port == port_t'(i)) r_cnt[i] <= r_cnt[i] + c_cnt_one;
            end
            r_total <= r_total + c_cnt_one;
        end
    end

    always_comb begin
        w_sel_cnt = '0;
        if (!bus.idx[2])
            w_sel_cnt = r_cnt[bus.idx[1:0]];
        else if (bus.idx == IDX_TOTAL)
            w_sel_cnt = r_total;
    end

    // Counter reads sample pre-edge values, so a same-cycle increment is not yet visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_salida    <= '0;
            r_valid_cnt <= 1'b0;
        end else begin
            r_valid_cnt <= bus.req;
            if (bus.req) r_salida <= w_sel_cnt;
        end
    end

    assign pop_fifo_azules     = r_pop;
    assign bus.data_out        = w_buf_data;
    assign bus.port_out        = w_buf_port;
    assign bus.valid_out       = w_valid;
    assign bus.salida_contador = r_salida;
    assign bus.valid_contador  = r_valid_cnt;
    assign idle = (r_pop == '0) && !r_tag_vld && (w_occ == 2'd0) && (&fifo_empty);

endmodule

`default_nettype wire
